// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the multiplier-sharing arbiter.
// The state encoding is fixed so that debug views can decode it.
package mult_arb_pkg;

    localparam int OP_W   = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr+1.
// The pointer register itself lives in the parent so it can be updated only on accept.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

    always_comb begin
        int idx;
        idx    = 0;
        gnt    = '0;
        gnt_id = '0;
        if (en) begin
            // Walk from lowest priority (ptr itself) to highest (ptr+1); the last hit wins.
            for (int k = N_REQ; k >= 1; k--) begin
                idx = (int'(ptr) + k) % N_REQ;
                if (req[idx]) begin
                    gnt      = '0;
                    gnt[idx] = 1'b1;
                    gnt_id   = ID_W'(idx);
                end
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative multiplier among N_REQ requesters: accept, run, respond.
// mult_begin is low in IDLE and RESP, so the multiplier always sees a re-arm gap.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int ID_W    = 1,
    parameter int MAX_CYC = 40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [OP_W*N_REQ-1:0]   req_op1,
    input  logic [OP_W*N_REQ-1:0]   req_op2,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [PROD_W-1:0]       resp_product,
    output logic                    resp_err,
    output logic                    busy,
    output logic                    mult_begin,
    output logic [OP_W-1:0]         mult_op1,
    output logic [OP_W-1:0]         mult_op2,
    input  logic [PROD_W-1:0]       product,
    input  logic                    mult_end
);

    localparam int               WD_W    = $clog2(MAX_CYC) + 1;
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(MAX_CYC - 1);
    localparam logic [ID_W-1:0]  PTR_RST = ID_W'(N_REQ - 1);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [OP_W-1:0]     op1_q, op1_d;
    logic [OP_W-1:0]     op2_q, op2_d;
    logic [PROD_W-1:0]   prod_q, prod_d;
    logic                err_q, err_d;
    logic [WD_W-1:0]     wd_q, wd_d;

    logic [N_REQ-1:0]    gnt;
    logic [ID_W-1:0]     gnt_id;
    logic [OP_W-1:0]     op1_arr [N_REQ];
    logic [OP_W-1:0]     op2_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ops
        assign op1_arr[gi] = req_op1[gi*OP_W +: OP_W];
        assign op2_arr[gi] = req_op2[gi*OP_W +: OP_W];
    end

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (state_q == S_IDLE),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        prod_d  = prod_q;
        err_d   = err_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                if (|gnt) begin
                    op1_d   = op1_arr[gnt_id];
                    op2_d   = op2_arr[gnt_id];
                    id_d    = gnt_id;
                    ptr_d   = gnt_id;
                    wd_d    = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                wd_d = wd_q + 1'b1;
                // A completion in the watchdog's last cycle still counts as success.
                if (mult_end) begin
                    prod_d  = product;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (wd_q == WD_LAST) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_RST;
            id_q    <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            prod_q  <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            prod_q  <= prod_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign req_ready    = gnt;
    assign busy         = (state_q != S_IDLE);
    assign mult_begin   = (state_q == S_RUN);
    assign resp_valid   = (state_q == S_RESP);
    assign resp_id      = id_q;
    assign resp_product = prod_q;
    assign resp_err     = err_q;
    assign mult_op1     = op1_q;
    assign mult_op2     = op2_q;

endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares the single iterative `multiply` unit between `N_REQ` requesters, such as the EXE-stage ALU and a debug/display port. The block accepts one request at a time through a valid/ready handshake, chosen by round-robin. It holds `mult_begin` high for the whole multiplication and captures the 64-bit product. It returns the product tagged with the requester ID, and guarantees that `mult_begin` is low for at least one cycle between operations so the multiplier re-arms.

## Interface
- `N_REQ`, default 2: number of requesters (2..8).
- `ID_W`, default 1: width of `resp_id`, equal to clog2(`N_REQ`), minimum 1.
- `MAX_CYC`, default 40: watchdog limit in cycles of `mult_begin`-high without `mult_end`.
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  N_REQ: per-requester request.
- `req_ready`  out  N_REQ: one-hot accept; at most one bit is high per cycle.
- `req_op1`  in  32*N_REQ: operand 1, requester i at bits [32i+31:32i].
- `req_op2`  in  32*N_REQ: operand 2, same packing as `req_op1`.
- `resp_valid`  out  1: result available.
- `resp_ready`  in  1: result consumed.
- `resp_id`  out  ID_W: index of the requester that owns the result.
- `resp_product`  out  64: captured product.
- `resp_err`  out  1: watchdog expired; `resp_product` is 0.
- `busy`  out  1: high in any state other than IDLE.
- `mult_begin`  out  1: to the multiplier.
- `mult_op1`, `mult_op2`  out  32: to the multiplier, driven from latched operand registers.
- `product`  in  64: from the multiplier.
- `mult_end`  in  1: from the multiplier; it is a level that stays high while `mult_begin` is high after completion.

## Operation
- **States:** IDLE, RUN, RESP.
- **IDLE**
  - If any `req_valid` bit is set, grant the first set bit at or after `ptr+1`, wrapping modulo `N_REQ`.
  - Assert `req_ready[g]` combinationally in the same cycle.
  - On the clock edge: latch that requester's operands into `op1_q`/`op2_q`, latch `g` into `id_q`, set `ptr <= g`, clear `wd_cnt`, and go to RUN.
- **RUN**
  - `mult_begin=1`; `mult_op1/op2 = op1_q/op2_q`, which stay stable for the whole operation; `wd_cnt` increments each cycle.
  - If `mult_end=1`: `prod_q <= product`, `err_q <= 0`, go to RESP.
  - Otherwise, if `wd_cnt == MAX_CYC-1`: `prod_q <= 0`, `err_q <= 1`, go to RESP.
  - `mult_end` takes priority over the watchdog when both occur in the same cycle.
- **RESP**
  - `mult_begin=0`, `resp_valid=1`, `resp_id=id_q`, `resp_product=prod_q`, `resp_err=err_q`.
  - When `resp_ready=1`, go to IDLE. `resp_*` outputs stay stable while stalled.
- `req_ready` is 0 in RUN and RESP. Requesters hold `req_valid` and operands until accepted.
- An accept cannot occur in the same cycle as `resp_valid && resp_ready`. The earliest next accept is the following cycle, in IDLE.
- `mult_end` is ignored outside RUN.
- Operands pass through unchanged; signedness is the multiplier's concern.

## Timing
- **Reset values:** state=IDLE, `ptr=N_REQ-1` (requester 0 wins first), `req_ready=0`, `resp_valid=0`, `resp_id=0`, `resp_product=0`, `resp_err=0`, `busy=0`, `mult_begin=0`, `mult_op1=0`, `mult_op2=0`.
- **Latency:** accept at cycle T. `mult_begin` rises at T+1. If `mult_end` is first seen at T+k, then `resp_valid` rises at T+k+1. Response-to-next-accept is at least 1 cycle, so `mult_begin` is low for at least 2 cycles between operations.
- **Throughput:** one operation per (multiplier latency + 3) cycles, assuming zero response stall.
- **Reset mid-operation** (RUN or RESP): next cycle is IDLE with `mult_begin=0`. The in-flight result is discarded and no response is issued.
- **Simultaneous requests:** only one is granted per accept. Losers keep `req_valid` high and win later by round-robin; there is no starvation beyond `N_REQ-1` operations.
- **`req_valid` dropped before accept:** legal; nothing is recorded.

## Structure
- Shared package/header `mult_arb_pkg`:
  - state encodings `S_IDLE=2'd0`, `S_RUN=2'd1`, `S_RESP=2'd2`
  - `OP_W=32`, `PROD_W=64`
- Sub-module `rr_arbiter`:
  - parameter `N_REQ`
  - inputs `req`, `ptr`, `en`
  - outputs one-hot `gnt` and encoded `gnt_id`
  - combinational only; `ptr` is owned by the `mult_arbiter` datapath
- All remaining logic (FSM, operand/result registers, watchdog) lives in `mult_arbiter`.

## Test plan
- **Single request:** requester 0 sends 0x0000_0003 × 0x0000_0005 → `req_ready[0]` in the same cycle, `mult_begin` high the next cycle, then `resp_valid` with `resp_product`=64'h0000_0000_0000_000F, `resp_id`=0, `resp_err`=0.
- **Round-robin fairness:** both requesters hold `req_valid` for 4 operations (op1=0xFFFF_FFFF, op2=0x2 for both) → grant order 0,1,0,1, every response has product 0x0000_0001_FFFF_FFFE, and `mult_begin` is low for at least 2 cycles between operations.
- **Response backpressure:** `resp_ready` held low 10 cycles → `resp_*` stable, `mult_begin`=0, `req_ready`=0 for all requesters, a new accept only after the handshake.
- **Watchdog:** multiplier model never raises `mult_end`, `MAX_CYC`=40 → `resp_valid` at T+41 with `resp_err`=1 and `resp_product`=0; the next request completes normally.
- **Reset mid-RUN:** assert `reset` 5 cycles into an operation → the next cycle shows state IDLE, `mult_begin`=0, no `resp_valid`, `ptr`=N_REQ-1; a later request from requester 1 succeeds.
- **Operand isolation:** change requester 0's `req_op1` to 0x7 during RUN after it was accepted with 0x3 (op2=0x5) → product is still 0xF, and `mult_op1` stays stable at 0x3 throughout.
